// File: rtl/mul_tree_fx_pipe.sv
// Pipelined fixed-point product tree for PC multiply nodes.
// Reduces N_IN unsigned Q0.DW leaves into per-mode group products.
module mul_tree_fx_pipe #(
  parameter int N_IN   = 8,
  parameter int DW     = 16,
  parameter int LOG2N  = $clog2(N_IN),
  parameter int MODE_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN*DW-1:0]       mul_ins,
  input  logic                     mul_stb,
  input  logic [MODE_W-1:0]        mode,
  output logic                     in_ready,
  output logic [(N_IN/2)*DW-1:0]   outputs,
  output logic                     out_stb,
  input  logic                     out_ready,
  output logic [MODE_W-1:0]        out_mode,
  output logic [N_IN/2-1:0]        uflow
);

  localparam int HALF = N_IN / 2;

  logic [N_IN-1:0][DW-1:0] in_d;
  logic                    in_v;
  logic [MODE_W-1:0]       in_m;

  logic [LOG2N-1:0][HALF-1:0][DW-1:0] st_d, nxt_d;
  logic [LOG2N-1:0][HALF-1:0]         st_nz, nxt_nz;
  logic [LOG2N-1:0]                   st_v, nxt_v;
  logic [LOG2N-1:0][MODE_W-1:0]       st_m, nxt_m;

  logic [N_IN-1:0][DW-1:0] src;
  logic [N_IN-1:0]         src_nz;
  logic                    adv;

  function automatic logic [DW-1:0] fx_mul(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return p[2*DW-1:DW];
  endfunction

  function automatic int grp(input logic [MODE_W-1:0] m);
    int g;
    g = int'(m) + 1;
    return (g > LOG2N) ? LOG2N : g;
  endfunction

  assign adv      = !st_v[LOG2N-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    nxt_d  = '0;
    nxt_nz = '0;
    nxt_v  = '0;
    nxt_m  = '0;
    src    = '0;
    src_nz = '0;
    nxt_v[0] = in_v;
    nxt_m[0] = in_m;
    for (int j = 0; j < HALF; j++) begin
      nxt_d[0][j]  = fx_mul(in_d[2*j], in_d[2*j+1]);
      nxt_nz[0][j] = (|in_d[2*j]) && (|in_d[2*j+1]);
    end
    // Upper half of src stays zero so pair indexing never leaves range.
    for (int s = 1; s < LOG2N; s++) begin
      nxt_v[s] = st_v[s-1];
      nxt_m[s] = st_m[s-1];
      src = '0;
      src_nz = '0;
      src[HALF-1:0] = st_d[s-1];
      src_nz[HALF-1:0] = st_nz[s-1];
      if (s + 1 <= grp(st_m[s-1])) begin
        for (int j = 0; j < HALF; j++) begin
          if (j < (N_IN >> (s + 1))) begin
            nxt_d[s][j]  = fx_mul(src[2*j], src[2*j+1]);
            nxt_nz[s][j] = src_nz[2*j] && src_nz[2*j+1];
          end
        end
      end else begin
        nxt_d[s]  = st_d[s-1];
        nxt_nz[s] = st_nz[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_d  <= '0;
      in_v  <= 1'b0;
      in_m  <= '0;
      st_d  <= '0;
      st_nz <= '0;
      st_v  <= '0;
      st_m  <= '0;
    end else if (adv) begin
      in_d  <= mul_ins;
      in_v  <= mul_stb;
      in_m  <= mode;
      st_d  <= nxt_d;
      st_nz <= nxt_nz;
      st_v  <= nxt_v;
      st_m  <= nxt_m;
    end
  end

  assign outputs  = st_d[LOG2N-1];
  assign out_stb  = st_v[LOG2N-1];
  assign out_mode = st_m[LOG2N-1];

  // Padding lanes carry nz=0, so they never flag.
  always_comb begin
    uflow = '0;
    for (int j = 0; j < HALF; j++)
      uflow[j] = st_nz[LOG2N-1][j] && (st_d[LOG2N-1][j] == '0);
  end

endmodule

// File: tb/tb_mul_tree_fx_pipe.sv
// Bench for mul_tree_fx_pipe: directed cases plus a random
// stream checked against a level-by-level reduction model.
module tb_mul_tree_fx_pipe;
  localparam int N_IN = 8;
  localparam int DW = 16;
  localparam int LOG2N = 3;
  localparam int HALF = 4;
  localparam int OW = HALF * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [N_IN*DW-1:0] mul_ins;
  logic mul_stb;
  logic [1:0] mode;
  logic in_ready;
  logic [OW-1:0] outputs;
  logic out_stb;
  logic out_ready;
  logic [1:0] out_mode;
  logic [HALF-1:0] uflow;

  mul_tree_fx_pipe #(.N_IN(N_IN), .DW(DW), .MODE_W(2)) dut (
    .clk(clk), .rst(rst), .mul_ins(mul_ins), .mul_stb(mul_stb),
    .mode(mode), .in_ready(in_ready), .outputs(outputs),
    .out_stb(out_stb), .out_ready(out_ready),
    .out_mode(out_mode), .uflow(uflow)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic [1:0] m;
    logic [HALF-1:0] u;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int popped = 0;
  int stall_cnt = 0;
  logic acc = 1'b0;
  logic stalled = 1'b0;
  logic [OW-1:0] snap = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(input logic [N_IN*DW-1:0] lv,
                                 input logic [1:0] m);
    exp_t r;
    longint v[N_IN];
    int g, n, gs;
    bit all_nz;
    r = '0;
    g = int'(m) + 1;
    if (g > LOG2N) g = LOG2N;
    n = N_IN;
    for (int i = 0; i < N_IN; i++) v[i] = longint'(lv[i*DW +: DW]);
    repeat (g) begin
      n = n / 2;
      for (int j = 0; j < n; j++) v[j] = (v[2*j] * v[2*j+1]) >> DW;
    end
    gs = 1 << g;
    for (int j = 0; j < n; j++) begin
      r.d[j*DW +: DW] = v[j][DW-1:0];
      all_nz = 1'b1;
      for (int k = 0; k < gs; k++)
        if (lv[(j*gs+k)*DW +: DW] == 0) all_nz = 1'b0;
      r.u[j] = all_nz && (v[j] == 0);
    end
    r.m = m;
    return r;
  endfunction

  function automatic logic [N_IN*DW-1:0] fill(input logic [15:0] x);
    return {N_IN{x}};
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      if (out_stb && !out_ready) begin
        stall_cnt++;
        chk("stall_in_ready", in_ready, 0);
        if (stalled) chk("stall_hold", outputs, snap);
        snap = outputs;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (out_stb && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          popped++;
          chk("data", outputs, e.d);
          chk("mode", out_mode, e.m);
          chk("uflow", uflow, e.u);
        end
      end
      if (mul_stb && in_ready) begin
        q.push_back(model(mul_ins, mode));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N_IN*DW-1:0] lv, input logic [1:0] m);
    mul_ins = lv;
    mode = m;
    mul_stb = 1'b1;
    tick();
    mul_stb = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_stb && n < 20) begin
      tick();
      n++;
    end
    chk("out_timeout", out_stb, 1);
  endtask

  initial begin
    logic [N_IN*DW-1:0] lz;
    int sent;
    int n0;
    rst = 1'b1;
    mul_stb = 1'b0;
    mode = 2'd0;
    mul_ins = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_stb", out_stb, 0);
    chk("rst_outputs", outputs, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_uflow", uflow, 0);
    chk("rst_in_ready", in_ready, 1);

    mul_ins = fill(16'h8000);
    mode = 2'd0;
    mul_stb = 1'b1;
    tick();
    mul_stb = 1'b0;
    tick();
    chk("lat_1", out_stb, 0);
    tick();
    chk("lat_2", out_stb, 0);
    tick();
    chk("lat_3", out_stb, 1);
    chk("m0_data", outputs, {4{16'h4000}});
    chk("m0_uflow", uflow, 0);
    chk("m0_mode", out_mode, 0);
    tick();

    send(fill(16'h8000), 2'd1);
    send(fill(16'h8000), 2'd2);
    wait_out();
    chk("m1_data", outputs, {16'h0, 16'h0, 16'h1000, 16'h1000});
    chk("m1_mode", out_mode, 1);
    tick();
    chk("m2_b2b", out_stb, 1);
    chk("m2_data", outputs, 64'h0000_0000_0000_0100);
    chk("m2_mode", out_mode, 2);
    tick();

    lz = fill(16'h8000);
    lz[DW-1:0] = '0;
    send(fill(16'h0001), 2'd0);
    send(fill(16'hFFFF), 2'd0);
    send(lz, 2'd0);
    wait_out();
    chk("tiny_data", outputs, 0);
    chk("tiny_uflow", uflow, 4'hF);
    tick();
    chk("max_data", outputs, {4{16'hFFFE}});
    chk("max_uflow", uflow, 0);
    tick();
    chk("zero_data", outputs, {16'h4000, 16'h4000, 16'h4000, 16'h0000});
    chk("zero_uflow", uflow, 0);
    tick();

    send(fill(16'h8000), 2'd3);
    wait_out();
    chk("m3_data", outputs, 64'h0000_0000_0000_0100);
    chk("m3_mode", out_mode, 3);
    tick();

    sent = 0;
    n0 = popped;
    stall_cnt = 0;
    for (int c = 0; c < 200 && (sent < 16 || q.size() > 0); c++) begin
      out_ready = !(c >= 10 && c < 13);
      if (!mul_stb && sent < 16) begin
        for (int i = 0; i < N_IN; i++)
          mul_ins[i*DW +: DW] = ($urandom_range(0, 7) == 0) ?
            16'($urandom_range(0, 3)) : 16'($urandom_range(16'h4000, 16'hFFFF));
        mode = 2'($urandom_range(0, 3));
        mul_stb = 1'b1;
      end
      tick();
      if (acc) begin
        sent++;
        mul_stb = 1'b0;
      end
    end
    mul_stb = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", popped - n0, 16);
    chk("stall_seen", stall_cnt >= 3, 1);

    send(fill(16'h8000), 2'd0);
    send(fill(16'hFFFF), 2'd1);
    rst = 1'b1;
    tick();
    q.delete();
    rst = 1'b0;
    chk("rst2_out_stb", out_stb, 0);
    chk("rst2_outputs", outputs, 0);
    chk("rst2_in_ready", in_ready, 1);
    repeat (6) begin
      tick();
      chk("no_stale", out_stb, 0);
    end
    send(fill(16'h8000), 2'd2);
    wait_out();
    chk("fresh_data", outputs, 64'h0000_0000_0000_0100);
    chk("fresh_mode", out_mode, 2);
    tick();

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
